// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: multi-cycle binary-to-BCD converter (shift-and-add-3).
// One input bit is consumed per clock. Results are registered and qualified
// by a one-cycle valid pulse.
// Optional build macro BIN_TO_BCD_BLANK_EN: leading zero digits in the result
// are replaced by the blank code 4'hF. Digit 0 is never blanked.
module bin_to_bcd_seq #(
  parameter int WIDTH    = 7,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_last;

  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bcd;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bcd_out;
  logic             r_ovf;
  logic             r_valid;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_nines;
  logic [BW-1:0]    w_bcd_shifted;
  logic             w_carry_next;
  logic [BW-1:0]    w_sat_val;
  logic [BW-1:0]    w_final;

  // Per-digit add-3 correction and the all-nines saturation constant.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4]   = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                             : r_bcd[4*gi +: 4];
      assign w_nines[4*gi +: 4] = 4'd9;
    end
  endgenerate

  // Shift the corrected BCD register left; the top bit leaving it is a carry
  // past the last digit and makes the overflow sticky.
  assign w_bcd_shifted = {w_adj[BW-2:0], r_shift[WIDTH-1]};
  assign w_carry_next  = r_carry | w_adj[BW-1];
  assign w_sat_val     = ((SATURATE != 0) && w_carry_next) ? w_nines : w_bcd_shifted;

`ifdef BIN_TO_BCD_BLANK_EN
  logic w_lead;

  // Blank leading zero digits of the completed value, scanning from the top.
  always_comb begin
    w_final = w_sat_val;
    w_lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w_lead && (w_sat_val[4*k +: 4] == 4'd0)) begin
        w_final[4*k +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  // Plain BCD result, leading zeros kept.
  always_comb begin
    w_final = w_sat_val;
  end
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept a start in IDLE, leave CONV on the last shift.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (r_cnt == CW'(1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // Datapath: load on accept, shift during conversion, publish on the last shift.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_accept) begin
        r_shift <= bin_i;
        r_bcd   <= '0;
        r_carry <= 1'b0;
        r_cnt   <= CW'(WIDTH);
      end else if (r_state == CONV) begin
        r_shift <= r_shift << 1;
        r_bcd   <= w_bcd_shifted;
        r_carry <= w_carry_next;
        r_cnt   <= r_cnt - CW'(1);
        if (w_last) begin
          r_bcd_out <= w_final;
          r_ovf     <= w_carry_next;
        end
      end
    end
  end

  assign busy_o     = (r_state == CONV);
  assign valid_o    = r_valid;
  assign bcd_o      = r_bcd_out;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: several parameterisations driven
// together, results compared against an arithmetic decimal reference.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start7 = 1'b0;
  logic [6:0]  bin7 = '0;
  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;

  logic        busy_a, valid_a, ovf_a;
  logic [7:0]  bcd_a;
  logic        busy_s, valid_s, ovf_s;
  logic [7:0]  bcd_s;
  logic        busy_d, valid_d, ovf_d;
  logic [11:0] bcd_d;
  logic        busy_w, valid_w, ovf_w;
  logic [15:0] bcd_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2), .SATURATE(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start7), .bin_i(bin7),
    .busy_o(busy_a), .valid_o(valid_a), .bcd_o(bcd_a), .overflow_o(ovf_a));

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start7), .bin_i(bin7),
    .busy_o(busy_s), .valid_o(valid_s), .bcd_o(bcd_s), .overflow_o(ovf_s));

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(3), .SATURATE(0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start7), .bin_i(bin7),
    .busy_o(busy_d), .valid_o(valid_d), .bcd_o(bcd_d), .overflow_o(ovf_d));

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4), .SATURATE(0)) u_sweep (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start10), .bin_i(bin10),
    .busy_o(busy_w), .valid_o(valid_w), .bcd_o(bcd_w), .overflow_o(ovf_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: value mod 10^digits (or all nines), split into digits.
  function automatic logic [19:0] ref_bcd(input int v, input int digits, input bit sat);
    int m;
    int r;
    logic [19:0] res;
    bit seen;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    if (v >= m) r = sat ? (m - 1) : (v % m);
    else        r = v;
    res = '0;
    for (int k = 0; k < digits; k++) begin
      res[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    seen = 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int k = digits - 1; k >= 1; k--) begin
      if (!seen && res[4*k +: 4] == 4'd0) res[4*k +: 4] = 4'hF;
      else seen = 1'b1;
    end
`endif
    return res;
  endfunction

  function automatic bit ref_ovf(input int v, input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return (v >= m);
  endfunction

  // Present a start on the 7-bit instances for one edge; returns after that edge.
  task automatic start7_conv(input int v);
    @(negedge clk);
    start7 = 1'b1;
    bin7   = v[6:0];
    @(negedge clk);
    start7 = 1'b0;
  endtask

  // Wait for completion of a 7-bit conversion of v. poke_n cycles of a
  // start(poke_v) are driven while busy; if chain, start(next_v) is raised
  // during the valid cycle.
  task automatic finish7(input int v, input int poke_n, input int poke_v,
                         input bit chain, input int next_v);
    int  lat;
    bit  busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    while (!valid_a && lat < 20) begin
      if (!(busy_a && busy_s && busy_d)) busy_ok = 1'b0;
      if (lat < poke_n) begin
        start7 = 1'b1;
        bin7   = poke_v[6:0];
      end else begin
        start7 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start7 = 1'b0;
    check("busy_during_conv", 32'(busy_ok), 32'd1);
    check("latency", lat, 7);
    check("busy_at_valid", 32'(busy_a), 32'd0);
    check("valid_sat", 32'(valid_s), 32'd1);
    check("valid_d3", 32'(valid_d), 32'd1);
    check("bcd_d2", 32'(bcd_a), 32'(ref_bcd(v, 2, 1'b0)));
    check("ovf_d2", 32'(ovf_a), 32'(ref_ovf(v, 2)));
    check("bcd_sat", 32'(bcd_s), 32'(ref_bcd(v, 2, 1'b1)));
    check("ovf_sat", 32'(ovf_s), 32'(ref_ovf(v, 2)));
    check("bcd_d3", 32'(bcd_d), 32'(ref_bcd(v, 3, 1'b0)));
    check("ovf_d3", 32'(ovf_d), 32'(ref_ovf(v, 3)));
    $display("conv7 v=%0d lat=%0d bcd2=%h ovf2=%b sat=%h bcd3=%h", v, lat, bcd_a, ovf_a, bcd_s, bcd_d);
    if (chain) begin
      start7 = 1'b1;
      bin7   = next_v[6:0];
    end
    @(negedge clk);
    start7 = 1'b0;
    check("valid_one_cycle", 32'(valid_a), 32'd0);
  endtask

  task automatic conv7(input int v);
    start7_conv(v);
    finish7(v, 0, 0, 1'b0, 0);
  endtask

  initial begin
    int  lat;
    bit  quiet;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;

    // Directed values and boundaries.
    conv7(42);
    conv7(127);
    conv7(0);
    conv7(7);
    conv7(10);
    conv7(99);
    conv7(100);

    // Start during busy is ignored.
    start7_conv(35);
    finish7(35, 2, 90, 1'b0, 0);

    // Start raised in the valid cycle is accepted back to back.
    start7_conv(35);
    finish7(35, 0, 0, 1'b1, 90);
    finish7(90, 0, 0, 1'b0, 0);

    // Reset in the middle of a conversion of 64.
    start7_conv(64);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'd0);
    check("abort_ovf", 32'(ovf_a), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (valid_a || busy_a) quiet = 1'b0;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(quiet), 32'd1);
    conv7(64);

    // Randomized values on the 7-bit instances.
    for (int i = 0; i < 40; i++) conv7(int'($urandom_range(0, 127)));

    // Full sweep of the 10-bit, 4-digit instance.
    for (int v = 0; v < 1024; v++) begin
      @(negedge clk);
      start10 = 1'b1;
      bin10   = v[9:0];
      @(negedge clk);
      start10 = 1'b0;
      lat = 0;
      while (!valid_w && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("sweep_latency", lat, 10);
      check("sweep_bcd", 32'(bcd_w), 32'(ref_bcd(v, 4, 1'b0)));
      check("sweep_ovf", 32'(ovf_w), 32'd0);
      $display("conv10 v=%0d lat=%0d bcd=%h ovf=%b", v, lat, bcd_w, ovf_w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
